// File: rtl/obi_error_responder.sv
// obi_error_responder: OBI slave terminating accesses that decode to no real slave.
// Grants every request, answers in order after LATENCY cycles (reads return a
// poison word), captures the first faulting access and raises a sticky interrupt.
module obi_error_responder #(
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] ERR_RDATA = 32'hBADACCE5,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    output logic             gnt_o,
    input  logic [31:0]      addr_i,
    input  logic             we_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic             rvalid_o,
    output logic [31:0]      rdata_o,
    input  logic             clear_i,
    output logic             err_irq_o,
    output logic             err_valid_o,
    output logic [31:0]      err_addr_o,
    output logic             err_we_o,
    output logic [3:0]       err_be_o,
    output logic [CNT_W-1:0] err_count_o
);

    localparam int unsigned PIPE_W = LATENCY + 1;

    logic               w_accept;
    logic [PIPE_W-1:0]  w_vld_chain;
    logic [PIPE_W-1:0]  w_rd_chain;
    logic               w_load_capture;
    logic               w_unused;

    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_rd;
    logic [31:0]        r_rdata;
    logic               r_err_valid;
    logic               r_err_irq;
    logic [31:0]        r_err_addr;
    logic               r_err_we;
    logic [3:0]         r_err_be;
    logic [CNT_W-1:0]   r_err_count;

    // Grant is the only combinational output; the block never back-pressures.
    assign gnt_o    = req_i;
    assign w_accept = req_i;

    // Chains of pipeline inputs: bit 0 is the new access, bit i is stage i-1.
    assign w_vld_chain = {r_vld, w_accept};
    assign w_rd_chain  = {r_rd, w_accept & ~we_i};

    // Accept wins over clear, and the first access after clear re-arms the capture.
    assign w_load_capture = w_accept & (clear_i | ~r_err_valid);

    // Write data is never stored; the final read-flag stage is superseded by r_rdata.
    assign w_unused = ^{wdata_i, w_rd_chain[LATENCY]};

    // Response pipeline: one {valid, is_read} entry per accepted access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld   <= '0;
            r_rd    <= '0;
            r_rdata <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                r_vld[i] <= w_vld_chain[i];
                r_rd[i]  <= w_rd_chain[i];
            end
            r_rdata <= w_rd_chain[LATENCY-1] ? ERR_RDATA : 32'h0;
        end
    end

    // First-fault capture and sticky interrupt.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_valid <= 1'b0;
            r_err_irq   <= 1'b0;
            r_err_addr  <= '0;
            r_err_we    <= 1'b0;
            r_err_be    <= '0;
        end else if (w_load_capture) begin
            r_err_valid <= 1'b1;
            r_err_irq   <= 1'b1;
            r_err_addr  <= addr_i;
            r_err_we    <= we_i;
            r_err_be    <= be_i;
        end else if (clear_i) begin
            r_err_valid <= 1'b0;
            r_err_irq   <= 1'b0;
            r_err_addr  <= '0;
            r_err_we    <= 1'b0;
            r_err_be    <= '0;
        end
    end

    // Saturating count of accepted accesses since the last clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err_count <= '0;
        end else if (clear_i) begin
            r_err_count <= w_accept ? CNT_W'(1) : '0;
        end else if (w_accept && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign rvalid_o    = w_vld_chain[LATENCY];
    assign rdata_o     = r_rdata;
    assign err_valid_o = r_err_valid;
    assign err_irq_o   = r_err_irq;
    assign err_addr_o  = r_err_addr;
    assign err_we_o    = r_err_we;
    assign err_be_o    = r_err_be;
    assign err_count_o = r_err_count;

endmodule

// File: tb/tb_obi_error_responder.sv
// Bench for obi_error_responder: five instances with different LATENCY/CNT_W
// share one stimulus stream; a response scoreboard checks timing and data.
module tb_obi_error_responder;

    localparam int unsigned NI  = 5;
    localparam logic [31:0] ERR = 32'hBADACCE5;

    function automatic int unsigned lat_of(int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned cw_of(int i);
        return (i == 2) ? 3 : 8;
    endfunction

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = '0;
    logic [31:0] wdata_i = '0;
    logic        clear_i = 1'b0;

    logic        w_gnt    [NI];
    logic        w_rvalid [NI];
    logic [31:0] w_rdata  [NI];
    logic        w_irq    [NI];
    logic        w_evalid [NI];
    logic [31:0] w_eaddr  [NI];
    logic        w_ewe    [NI];
    logic [3:0]  w_ebe    [NI];
    logic [7:0]  w_cnt    [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned LAT = lat_of(g);
        localparam int unsigned CW  = cw_of(g);
        logic [CW-1:0] cnt;
        obi_error_responder #(.LATENCY(LAT), .ERR_RDATA(ERR), .CNT_W(CW)) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_ni),
            .req_i      (req_i),
            .gnt_o      (w_gnt[g]),
            .addr_i     (addr_i),
            .we_i       (we_i),
            .be_i       (be_i),
            .wdata_i    (wdata_i),
            .rvalid_o   (w_rvalid[g]),
            .rdata_o    (w_rdata[g]),
            .clear_i    (clear_i),
            .err_irq_o  (w_irq[g]),
            .err_valid_o(w_evalid[g]),
            .err_addr_o (w_eaddr[g]),
            .err_we_o   (w_ewe[g]),
            .err_be_o   (w_ebe[g]),
            .err_count_o(cnt)
        );
        assign w_cnt[g] = 8'(cnt);
    end

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];
    int   ptr [NI];
    int   flush_base = 0;
    int   cyc = 0;
    int   n_app = 0;
    int   n_err = 0;

    // Reference model of the capture/counter state.
    logic        m_valid = 1'b0;
    logic [31:0] m_addr = '0;
    logic        m_we = 1'b0;
    logic [3:0]  m_be = '0;
    int          m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Response monitor: each instance walks the shared expected-response log.
    initial begin
        for (int i = 0; i < NI; i++) ptr[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (ptr[i] < flush_base) ptr[i] = flush_base;
                if (!rst_ni) begin
                    chk($sformatf("rvalid_in_reset%0d", i), 32'(w_rvalid[i]), 32'h0);
                end else if (w_rvalid[i]) begin
                    if (ptr[i] >= q.size()) begin
                        chk($sformatf("unexpected_rvalid%0d", i), 32'h1, 32'h0);
                    end else begin
                        chk($sformatf("rvalid_cycle%0d", i), 32'(cyc),
                            32'(q[ptr[i]].cyc + int'(lat_of(i))));
                        chk($sformatf("rdata%0d", i), w_rdata[i], q[ptr[i]].rdata);
                        ptr[i]++;
                    end
                end else begin
                    chk($sformatf("rdata_idle%0d", i), w_rdata[i], 32'h0);
                    if (ptr[i] < q.size() && cyc >= q[ptr[i]].cyc + int'(lat_of(i))) begin
                        chk($sformatf("missed_rvalid%0d", i), 32'h0, 32'h1);
                        ptr[i]++;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic clr);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        be_i    = be;
        wdata_i = $urandom;
        clear_i = clr;
        q.push_back('{cyc: cyc, rdata: (we ? 32'h0 : ERR)});
        if (clr || !m_valid) begin
            m_valid = 1'b1;
            m_addr  = addr;
            m_we    = we;
            m_be    = be;
        end
        m_cnt = clr ? 1 : m_cnt + 1;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("gnt%0d", i), 32'(w_gnt[i]), 32'h1);
        step();
        req_i   = 1'b0;
        clear_i = 1'b0;
    endtask

    task automatic clear_pulse();
        clear_i = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_we    = 1'b0;
        m_be    = '0;
        m_cnt   = 0;
        step();
        clear_i = 1'b0;
    endtask

    task automatic check_capture(input string tag);
        int unsigned sat;
        for (int i = 0; i < NI; i++) begin
            sat = (32'd1 << cw_of(i)) - 32'd1;
            chk($sformatf("%s_irq%0d", tag, i), 32'(w_irq[i]), 32'(m_valid));
            chk($sformatf("%s_valid%0d", tag, i), 32'(w_evalid[i]), 32'(m_valid));
            chk($sformatf("%s_addr%0d", tag, i), w_eaddr[i], m_addr);
            chk($sformatf("%s_we%0d", tag, i), 32'(w_ewe[i]), 32'(m_we));
            chk($sformatf("%s_be%0d", tag, i), 32'(w_ebe[i]), 32'(m_be));
            chk($sformatf("%s_cnt%0d", tag, i), 32'(w_cnt[i]),
                (32'(m_cnt) > sat) ? sat : 32'(m_cnt));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_rvalid%0d", tag, i), 32'(w_rvalid[i]), 32'h0);
            chk($sformatf("%s_rdata%0d", tag, i), w_rdata[i], 32'h0);
        end
        check_capture(tag);
    endtask

    initial begin
        // Reset state; grant follows request even in reset.
        step();
        req_i = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("rst_gnt_hi%0d", i), 32'(w_gnt[i]), 32'h1);
        req_i = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) chk($sformatf("rst_gnt_lo%0d", i), 32'(w_gnt[i]), 32'h0);
        check_reset_outputs("reset");
        step();
        rst_ni = 1'b1;
        idle(2);

        // Single read at the error window base.
        issue(1'b0, 32'hBADACCE5, 4'hF, 1'b0);
        check_capture("read");
        chk("read_addr_const", w_eaddr[0], 32'hBADACCE5);
        chk("read_cnt_const", 32'(w_cnt[0]), 32'd1);
        idle(10);

        // Clear alone, then a single write.
        clear_pulse();
        check_capture("clear1");
        issue(1'b1, 32'h00001234, 4'h3, 1'b0);
        check_capture("write");
        chk("write_we_const", 32'(w_ewe[2]), 32'h1);
        idle(10);

        // Back-to-back stream with alternating direction.
        clear_pulse();
        for (int k = 0; k < 5; k++)
            issue(k[0], 32'h0000_0100 + 32'(k * 4), 4'(k + 1), 1'b0);
        check_capture("stream");
        chk("stream_cnt_const", 32'(w_cnt[1]), 32'd5);
        idle(10);

        // Saturation: 10 more accepts push the 3-bit counter to its ceiling.
        for (int k = 0; k < 10; k++)
            issue(1'b0, 32'h0000_2000 + 32'(k), 4'hF, 1'b0);
        check_capture("sat");
        chk("sat_cnt3_const", 32'(w_cnt[2]), 32'd7);
        idle(10);

        // Clear while responses are still in flight.
        issue(1'b0, 32'h0000_3000, 4'hF, 1'b0);
        issue(1'b1, 32'h0000_3004, 4'hC, 1'b0);
        clear_pulse();
        check_capture("clear_inflight");
        idle(10);

        // Clear coinciding with an accept: the accept wins.
        issue(1'b0, 32'h0000_5000, 4'hF, 1'b0);
        issue(1'b1, 32'h0000_0040, 4'h1, 1'b1);
        check_capture("clear_accept");
        chk("clear_accept_addr_const", w_eaddr[3], 32'h40);
        chk("clear_accept_cnt_const", 32'(w_cnt[3]), 32'd1);
        idle(10);

        // Reset with responses outstanding flushes them.
        issue(1'b0, 32'h0000_6000, 4'hF, 1'b0);
        issue(1'b1, 32'h0000_6004, 4'hF, 1'b0);
        flush_base = q.size();
        rst_ni  = 1'b0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_we    = 1'b0;
        m_be    = '0;
        m_cnt   = 0;
        #1;
        check_reset_outputs("midrst");
        idle(2);
        rst_ni = 1'b1;
        idle(12);
        check_reset_outputs("postrst");

        for (int i = 0; i < NI; i++)
            chk($sformatf("drained%0d", i), 32'(ptr[i]), 32'(q.size()));

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before bound");
        $fatal(1);
    end

endmodule
